// File: rtl/register_lanes_shift.sv
// register_lanes_shift
// Lane-loadable datapath register with a multi-cycle right-shift engine.
// The register is W bits wide, split into LANES lanes, and each lane has its
// own load enable. A shift sequence is started with shift_start. It runs for
// min(shift_count, W) cycles, and busy is high while it runs. done pulses
// for one cycle when the sequence completes.
// Build option: define REGISTER_LANES_SHIFT_ROTATE_EN to enable two extra
// modes, rotate right (mode=2'b10) and logical left shift (mode=2'b11).
// Without the macro, mode[1] is ignored.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepts lane loads, sclr and shift_start
// SHIFT | one 1-bit shift per cycle, counter counts down to 1

module register_lanes_shift #(
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int CW    = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [W-1:0]     din,
    input  logic [LANES-1:0] load,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic             shift_start,
    input  logic [CW-1:0]    shift_count,
    output logic [W-1:0]     out,
    output logic             busy,
    output logic             done
);

    localparam int LW = W / LANES;
    localparam logic [CW-1:0] W_C = CW'(W);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      mode_q, mode_next;
    logic [W-1:0]    out_next;
    logic            done_next;
    logic [W-1:0]    loaded;
    logic [CW-1:0]   cnt_sat;

    // One step of the selected shift operation
    function automatic logic [W-1:0] shift_fn(input logic [W-1:0] v, input logic [1:0] m);
`ifdef REGISTER_LANES_SHIFT_ROTATE_EN
        case (m)
            2'b00:   shift_fn = {1'b0, v[W-1:1]};
            2'b01:   shift_fn = {v[W-1], v[W-1:1]};
            2'b10:   shift_fn = {v[0], v[W-1:1]};
            default: shift_fn = {v[W-2:0], 1'b0};
        endcase
`else
        shift_fn = m[0] ? {v[W-1], v[W-1:1]} : {1'b0, v[W-1:1]};
`endif
    endfunction

`ifndef REGISTER_LANES_SHIFT_ROTATE_EN
    // mode[1] has no effect in the base build
    logic unused_mode_hi;
    assign unused_mode_hi = mode_q[1];
`endif

    // Per-lane merge of din into the current contents
    always_comb begin
        loaded = out;
        for (int k = 0; k < LANES; k++) begin
            if (load[k]) loaded[k*LW +: LW] = din[k*LW +: LW];
        end
    end

    // Requested count saturated to the register width
    always_comb begin
        cnt_sat = (shift_count > W_C) ? W_C : shift_count;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            out    <= '0;
            cnt    <= '0;
            mode_q <= 2'b00;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            out    <= out_next;
            cnt    <= cnt_next;
            mode_q <= mode_next;
            done   <= done_next;
        end
    end

    // Next-state and datapath update; sclr has the highest priority in both states
    always_comb begin
        state_next = state;
        out_next   = out;
        cnt_next   = cnt;
        mode_next  = mode_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (sclr) begin
                    out_next = '0;
                end else begin
                    out_next = loaded;
                    if (shift_start) begin
                        mode_next = mode;
                        cnt_next  = cnt_sat;
                        if (cnt_sat == '0) done_next = 1'b1;
                        else               state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (sclr) begin
                    out_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    out_next = shift_fn(out, mode_q);
                    cnt_next = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == SHIFT);
    end

endmodule

// File: tb/tb_register_lanes_shift.sv
// Testbench for register_lanes_shift (W=16, LANES=2).
// Shift requests push their expected result onto a scoreboard. A monitor
// compares that result against the DUT whenever done pulses.

module tb_register_lanes_shift;

    localparam int W = 16;
    localparam int LANES = 2;
    localparam int CW = $clog2(W + 1);

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic [W-1:0]     din = '0;
    logic [LANES-1:0] load = '0;
    logic             sclr = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             shift_start = 1'b0;
    logic [CW-1:0]    shift_count = '0;
    logic [W-1:0]     out;
    logic             busy;
    logic             done;

    int asserts = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [W-1:0] val;
        int           busy_cycles;
    } exp_t;

    exp_t sb[$];

    register_lanes_shift #(.W(W), .LANES(LANES)) dut (
        .clk(clk), .clear(clear), .din(din), .load(load), .sclr(sclr),
        .mode(mode), .shift_start(shift_start), .shift_count(shift_count),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply current inputs at the next edge, then return them to idle values
    task automatic step();
        @(posedge clk);
        #1;
        load = '0;
        shift_start = 1'b0;
        sclr = 1'b0;
        din = '0;
    endtask

    task automatic start(input string name, input logic [1:0] ld, input logic [W-1:0] d,
                         input logic [1:0] m, input int cnt, input logic [W-1:0] exp_val,
                         input int exp_busy, input bit expect_done);
        exp_t e;
        load = ld;
        din = d;
        mode = m;
        shift_count = CW'(cnt);
        shift_start = 1'b1;
        if (expect_done) begin
            e.name = name;
            e.val = exp_val;
            e.busy_cycles = exp_busy;
            sb.push_back(e);
        end
        step();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            asserts++;
            failures++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    // Monitor: counts busy cycles and checks each done pulse against the scoreboard
    initial begin : monitor
        int busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                asserts++;
                if (busy) begin
                    failures++;
                    $display("FAIL done_with_busy: busy %b, required 0", busy);
                end
                if (sb.size() == 0) begin
                    asserts++;
                    failures++;
                    $display("FAIL unexpected_done: out %h, scoreboard empty", out);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_out"}, out, e.val);
                    asserts++;
                    if (busy_run != e.busy_cycles) begin
                        failures++;
                        $display("FAIL %s_busy: got %0d busy cycles expected %0d",
                                 e.name, busy_run, e.busy_cycles);
                    end
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);
        check("reset_done", {15'd0, done}, 16'h0000);
        clear = 1'b0;

        load = 2'b01; din = 16'hABCD; step();
        check("lane0_load", out, 16'h00CD);
        load = 2'b10; din = 16'h1234; step();
        check("lane1_load", out, 16'h12CD);
        load = 2'b11; din = 16'h5A5A; step();
        check("both_load", out, 16'h5A5A);
        sclr = 1'b1; load = 2'b11; din = 16'hFFFF; step();
        check("sclr_over_load", out, 16'h0000);

        // Arithmetic and logical shifts; load on the start edge is applied first
        start("arith4", 2'b11, 16'h8010, 2'b01, 4, 16'hF801, 4, 1'b1);
        wait_idle("arith4");
        start("logic4", 2'b11, 16'h8010, 2'b00, 4, 16'h0801, 4, 1'b1);
        wait_idle("logic4");

        // Zero count and saturation
        start("zero", 2'b00, 16'h0000, 2'b00, 0, 16'h0801, 0, 1'b1);
        step();
        start("sat31", 2'b11, 16'h8000, 2'b01, 31, 16'hFFFF, 16, 1'b1);
        wait_idle("sat31");

        // Load and start while busy are ignored
        start("ignore", 2'b11, 16'hF0F0, 2'b00, 3, 16'h1E1E, 3, 1'b1);
        load = 2'b11; din = 16'hFFFF; shift_start = 1'b1; shift_count = CW'(5); mode = 2'b01;
        step();
        wait_idle("ignore");
        step();

        // sclr abort in the second shift cycle
        start("abort_sclr", 2'b11, 16'h8010, 2'b01, 4, 16'h0000, 0, 1'b0);
        step();
        sclr = 1'b1;
        step();
        check("sclr_abort_out", out, 16'h0000);
        check("sclr_abort_busy", {15'd0, busy}, 16'h0000);
        step();
        check("sclr_abort_nodone", {15'd0, done}, 16'h0000);

        // Asynchronous clear mid-sequence
        start("abort_clear", 2'b11, 16'h8010, 2'b01, 4, 16'h0000, 0, 1'b0);
        step();
        #2;
        clear = 1'b1;
        #1;
        check("clear_async_out", out, 16'h0000);
        check("clear_async_busy", {15'd0, busy}, 16'h0000);
        clear = 1'b0;
        step();
        check("clear_nodone", {15'd0, done}, 16'h0000);
        start("after_clear", 2'b11, 16'h0F00, 2'b00, 2, 16'h03C0, 2, 1'b1);
        wait_idle("after_clear");
        step();

`ifdef REGISTER_LANES_SHIFT_ROTATE_EN
        start("rot1", 2'b11, 16'h0001, 2'b10, 1, 16'h8000, 1, 1'b1);
        wait_idle("rot1");
        start("left4", 2'b11, 16'h0F00, 2'b11, 4, 16'hF000, 4, 1'b1);
        wait_idle("left4");
        start("rotW", 2'b11, 16'h1234, 2'b10, 20, 16'h1234, 16, 1'b1);
        wait_idle("rotW");
`else
        start("m10_1", 2'b11, 16'h0001, 2'b10, 1, 16'h0000, 1, 1'b1);
        wait_idle("m10_1");
        start("m10_4", 2'b11, 16'h8000, 2'b10, 4, 16'h0800, 4, 1'b1);
        wait_idle("m10_4");
`endif
        step();
        step();

        asserts++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
